// File: rtl/uart_rx_8n1_sync.sv
// uart_rx_8n1_sync: single-clock 8N1 UART receiver with valid/ready holding register; define UART_RX_MAJORITY_EN for 3-sample majority voting
module uart_rx_8n1_sync #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bidx_q;
  logic [7:0] shift_q;
  logic done_q;
  logic rx_s;
  logic samp;
  assign rx_s = sync_q[1];
  assign rx_busy = state_q != IDLE;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_END = CW'(HALF_BIT);
  logic prev2_q;
  always_ff @(posedge clk) prev2_q <= rst ? 1'b1 : prev_q;
  assign samp = (rx_s & prev_q) | (rx_s & prev2_q) | (prev_q & prev2_q);
`else
  localparam logic [CW-1:0] START_END = CW'(HALF_BIT - 1);
  assign samp = rx_s;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      bidx_q <= '0;
      shift_q <= '0;
      done_q <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      prev_q <= rx_s;
      cnt_q <= cnt_q + 1'b1;
      done_q <= 1'b0;
      frame_err <= 1'b0;
      overrun_err <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (prev_q && !rx_s) state_q <= START;
        end
        START: if (cnt_q == START_END) begin
          cnt_q <= '0;
          bidx_q <= '0;
          state_q <= samp ? IDLE : DATA;
        end
        DATA: if (cnt_q == LAST) begin
          cnt_q <= '0;
          shift_q[bidx_q] <= samp;
          bidx_q <= bidx_q + 1'b1;
          if (bidx_q == 3'd7) state_q <= STOP;
        end
        STOP: if (cnt_q == LAST) begin
          cnt_q <= '0;
          state_q <= samp ? IDLE : WAIT_HIGH;
          done_q <= samp;
          frame_err <= !samp;
        end
        WAIT_HIGH: begin
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_rx_8n1_sync.md
Name: uart_rx_8n1_sync

Overview:
- Single-clock 8N1 UART receiver. It consumes the serial line driven by the team's 8N1 transmitter, which is fed by the baud clock generator.
- Runs on the system clock with a bit-period counter instead of a separate baud clock.
- Delivers each received byte on a valid/ready handshake with a one-byte holding register.
- Used for loopback checks of the TX path and for host→FPGA command input.

Parameters:
- CLKS_PER_BIT, 1250, system clock cycles per bit (12 MHz / 9600 baud). Legal range is 8 or more.
- HALF_BIT, CLKS_PER_BIT/2, offset from start edge to start-bit mid-sample (integer division).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts byte when rx_valid&rx_ready on a posedge.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun_err  output  1  one-cycle pulse: byte completed while holding register full; new byte dropped.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Input sync: rx_in passes through a 2-FF synchronizer; both FFs reset to 1. All decisions use the 2nd FF (rx_s). Edge detect compares rx_s with its previous value (also reset to 1).
- Reset: state=IDLE, counters 0, shift register 0. rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, rx_busy=0. Reset mid-frame aborts the frame, clears rx_valid and drops any held byte. Receiver resumes on the next falling edge after rst deasserts.
- Bit counter cnt: 0..CLKS_PER_BIT-1, cleared on every state entry. Bit index bidx: 0..7.
- IDLE → START on a falling edge of rx_s.
- START: at cnt==HALF_BIT-1, sample rx_s.
  - If 0, go to DATA (cnt=0, bidx=0).
  - If 1, treat as a glitch: return to IDLE with no error pulse.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift[bidx] (LSB first).
  - After bidx==7, go to STOP; otherwise bidx+1.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1, deliver the byte and go to IDLE.
  - If 0, pulse frame_err, discard the byte and go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Delivery, in the cycle after the stop sample:
  - If rx_valid==0, or rx_valid&rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - Otherwise: pulse overrun_err and keep the old rx_data/rx_valid.
- Handshake: rx_valid falls on the posedge where rx_valid&rx_ready=1, unless a new byte is loaded in that same cycle, in which case it stays high with the new data. rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises between 9.5·CLKS_PER_BIT+2 and 9.5·CLKS_PER_BIT+5 clk cycles after the falling edge at rx_in.
- Back-to-back frames: a falling edge detected in IDLE one cycle after the STOP sample starts a new frame. The receiver tolerates the next start edge at 9.5 bit periods.
- Frame and overrun pulses can never occur in the same cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each mid-bit sample (START, DATA, STOP) is the majority of rx_s at cnt-1, cnt and cnt+1 around the nominal sample point. The decision is registered 1 cycle later and all sample points shift by +1 cycle. Latency bounds grow by 1.
- Undefined: a single sample at the nominal point; no extra logic.

Test Plan (CLKS_PER_BIT=16, rx_ready held 1 unless stated):
- Send 0x55 then 0xA3 back-to-back with ideal timing → rx_valid pulses twice, rx_data=0x55 then 0xA3, no error pulses, each within the latency window.
- 3-cycle low glitch on idle rx_in → stays in IDLE after START check, no rx_valid, no frame_err, rx_busy high for ≤HALF_BIT+3 cycles.
- Send 0x3C with stop bit forced 0 and the line held low 40 cycles → exactly one frame_err pulse, no rx_valid, then 0x81 sent after the line returns high is received correctly.
- rx_ready=0; send 0x11 then 0x22 → rx_valid=1 with rx_data=0x11, one overrun_err pulse at 0x22 completion. Raise rx_ready → rx_valid drops next cycle, rx_data stays 0x11.
- Assert rst for 1 cycle during DATA bit 4 of 0xF0 → all outputs 0. The following byte 0x7E is received correctly with no spurious frame_err.
- With UART_RX_MAJORITY_EN, a 1-cycle inverted spike at the mid-point of every data bit of 0x96 → rx_data=0x96. Without the macro, the same stimulus yields corrupted data (documents the feature).
